arc4_seq: RTL and testbench
===========================

Name: arc4_seq

Overview:
- Top-level sequencer for the ARC4 datapath.
- On one start request it runs the three S-memory engines in fixed order: init (S[i]=i), ksa (key schedule), prga (keystream/decrypt).
- Owns the single S-memory write/address port. Muxes the active engine's addr/wrdata/wren onto it and keeps idle engines off the port.
- Every engine uses the en/rdy handshake: rdy=1 means idle; a one-cycle en while rdy=1 starts work; rdy falls, then rises again when the engine is done.

Parameters:
- AW, 8, S-memory address width.
- DW, 8, S-memory data width.
- TIMEOUT, 0, max cycles in any single wait state before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  sequencer idle and ready
- err  out  1  sticky timeout flag; cleared on next accepted start
- phase  out  2  current owner of the memory port: 0 none, 1 init, 2 ksa, 3 prga
- init_en  out  1  start pulse to init
- init_rdy  in  1  init ready
- init_addr  in  AW  init memory address
- init_wrdata  in  DW  init write data
- init_wren  in  1  init write enable
- ksa_en  out  1  start pulse to ksa
- ksa_rdy  in  1  ksa ready
- ksa_addr  in  AW  ksa memory address
- ksa_wrdata  in  DW  ksa write data
- ksa_wren  in  1  ksa write enable
- prga_en  out  1  start pulse to prga
- prga_rdy  in  1  prga ready
- prga_addr  in  AW  prga memory address
- prga_wrdata  in  DW  prga write data
- prga_wren  in  1  prga write enable
- s_addr  out  AW  S-memory address
- s_wrdata  out  DW  S-memory write data
- s_wren  out  1  S-memory write enable

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low. All state is reset to IDLE, independent of clk.
- Reset values: rdy=1, err=0, phase=0, all *_en=0, s_wren=0, s_addr=0, s_wrdata=0.
- States: IDLE, ST_INIT, WT_INIT, ST_KSA, WT_KSA, ST_PRGA, WT_PRGA.
- IDLE:
  - rdy=1.
  - en=1 at a clock edge: go to ST_INIT, rdy=0 from the next cycle, err cleared.
  - en while rdy=0 is ignored and is not queued.
- ST_x:
  - x_en = (state==ST_x) && x_rdy, combinational, so exactly one cycle high.
  - If x_rdy=0, stay in ST_x with x_en=0 until x_rdy=1.
  - Leave ST_x for WT_x on the edge where x_en=1.
- WT_x:
  - A seen_busy flag is cleared on entry and set on any cycle with x_rdy=0.
  - Advance when seen_busy && x_rdy. This tolerates engines whose rdy drops one cycle late.
  - Transitions: WT_INIT to ST_KSA, WT_KSA to ST_PRGA, WT_PRGA to IDLE. rdy=1 in the cycle after the WT_PRGA exit edge.
  - No cycle is spent in an extra DONE state.
- Start latency: en sampled at edge N gives init_en high during cycle N+1 (given init_rdy=1).
- Phase-to-phase gap: 1 cycle (the ST_x cycle) when the next engine is ready.
- phase: 1 in ST_INIT/WT_INIT, 2 in ST_KSA/WT_KSA, 3 in ST_PRGA/WT_PRGA, 0 in IDLE. Registered as part of state.
- Memory mux:
  - Combinational, zero latency, selected by phase.
  - phase=0 forces s_wren=0, s_addr=0, s_wrdata=0.
  - A non-owning engine's wren never reaches s_wren, even if it is asserted (protocol error upstream, masked here).
- Watchdog (TIMEOUT>0):
  - A counter of width ceil(log2(TIMEOUT+1)) clears on entry to each ST_x and counts every cycle in ST_x/WT_x.
  - When count reaches TIMEOUT: next state IDLE, err=1 (sticky), all *_en=0.
  - Engines are not reset by the sequencer; the owner reinitialises them via rst_n.
  - With TIMEOUT=0 the counter is never compared.
- Simultaneous events: exit from WT_PRGA to IDLE and en=1 on the next edge start a new run immediately (back-to-back runs allowed). Timeout and normal completion on the same edge: completion wins, err stays 0.
- Reset mid-operation: immediate return to IDLE and reset values. s_wren drops asynchronously with rst_n.

Test Plan:
- Nominal run:
  - Stimulus: behavioural engines with busy lengths init=256, ksa=768, prga=300. Pulse en for one cycle at t0.
  - Required: init_en high exactly once at t0+1; phase goes 1, 2, 3, 0; each x_en is a one-cycle pulse one cycle after the previous engine's rdy rises; rdy returns 1 and err=0.
- Mux isolation:
  - Stimulus: ksa drives ksa_wren=1, ksa_addr=8'h55 during phase=1.
  - Required: s_wren equals init_wren and s_addr equals init_addr. With phase=0 and all engines writing, s_wren=0 and s_addr=0.
- Late/not-ready engines:
  - Stimulus 1: hold ksa_rdy=0 for 5 cycles at ST_KSA entry. Required: ksa_en stays 0 for 5 cycles, then a single one-cycle pulse.
  - Stimulus 2: an engine whose rdy falls 2 cycles after en. Required: the sequencer does not advance early.
- Ignored start:
  - Stimulus: en=1 held continuously across a whole run.
  - Required: only one init_en per run while busy; a new run starts on the edge after rdy returns.
- Watchdog:
  - Stimulus: TIMEOUT=16, prga never re-asserts rdy.
  - Required: at count 16, phase goes to 0, rdy=1, err=1. err stays 1 until the next accepted en clears it.
- Async reset:
  - Stimulus: assert rst_n=0 for 10 ps mid-WT_KSA, between clock edges.
  - Required: s_wren=0, phase=0, rdy=1 immediately; a fresh en afterwards restarts from init.

Source files
------------

// File: rtl/arc4_seq.sv
// ARC4 top-level sequencer: runs init, ksa and prga in order on one start
// request and multiplexes the owning engine onto the single S-memory port.
module arc4_seq #(
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int TIMEOUT = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   output logic          rdy,
   output logic          err,
   output logic [1:0]    phase,
   output logic          init_en,
   input  logic          init_rdy,
   input  logic [AW-1:0] init_addr,
   input  logic [DW-1:0] init_wrdata,
   input  logic          init_wren,
   output logic          ksa_en,
   input  logic          ksa_rdy,
   input  logic [AW-1:0] ksa_addr,
   input  logic [DW-1:0] ksa_wrdata,
   input  logic          ksa_wren,
   output logic          prga_en,
   input  logic          prga_rdy,
   input  logic [AW-1:0] prga_addr,
   input  logic [DW-1:0] prga_wrdata,
   input  logic          prga_wren,
   output logic [AW-1:0] s_addr,
   output logic [DW-1:0] s_wrdata,
   output logic          s_wren
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE, ST_INIT, WT_INIT, ST_KSA, WT_KSA, ST_PRGA, WT_PRGA
   } state_t;

   state_t        state, state_nx;
   logic          busy_seen, busy_seen_nx;
   logic          err_q, err_nx;
   logic [CW-1:0] wd_cnt, wd_cnt_nx;
   logic          eng_rdy, is_st, is_wt, timeout, launch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy_seen <= 1'b0;
         err_q     <= 1'b0;
         wd_cnt    <= '0;
      end else begin
         state     <= state_nx;
         busy_seen <= busy_seen_nx;
         err_q     <= err_nx;
         wd_cnt    <= wd_cnt_nx;
      end
   end

   // phase is a pure decode of the state register, so it is glitch-free
   always_comb begin
      phase = 2'd0;
      is_st = 1'b0;
      is_wt = 1'b0;
      case (state)
         ST_INIT: begin phase = 2'd1; is_st = 1'b1; end
         WT_INIT: begin phase = 2'd1; is_wt = 1'b1; end
         ST_KSA:  begin phase = 2'd2; is_st = 1'b1; end
         WT_KSA:  begin phase = 2'd2; is_wt = 1'b1; end
         ST_PRGA: begin phase = 2'd3; is_st = 1'b1; end
         WT_PRGA: begin phase = 2'd3; is_wt = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      eng_rdy = 1'b0;
      case (phase)
         2'd1:    eng_rdy = init_rdy;
         2'd2:    eng_rdy = ksa_rdy;
         2'd3:    eng_rdy = prga_rdy;
         default: ;
      endcase
   end

   assign timeout = (TIMEOUT != 0) && (wd_cnt == TMAX);

   // Completion is checked before the watchdog so a same-edge finish keeps err clear
   always_comb begin
      state_nx     = state;
      busy_seen_nx = busy_seen;
      err_nx       = err_q;
      wd_cnt_nx    = wd_cnt;
      launch       = 1'b0;
      if (state != IDLE && TIMEOUT != 0) wd_cnt_nx = wd_cnt + 1'b1;
      if (state == IDLE) begin
         if (en) begin
            state_nx  = ST_INIT;
            err_nx    = 1'b0;
            wd_cnt_nx = '0;
         end
      end else if (is_wt && busy_seen && eng_rdy) begin
         wd_cnt_nx = '0;
         case (state)
            WT_INIT: state_nx = ST_KSA;
            WT_KSA:  state_nx = ST_PRGA;
            default: state_nx = IDLE;
         endcase
      end else if (timeout) begin
         state_nx = IDLE;
         err_nx   = 1'b1;
      end else if (is_st && eng_rdy) begin
         launch       = 1'b1;
         busy_seen_nx = 1'b0;
         case (state)
            ST_INIT: state_nx = WT_INIT;
            ST_KSA:  state_nx = WT_KSA;
            default: state_nx = WT_PRGA;
         endcase
      end else if (is_wt && !eng_rdy) begin
         busy_seen_nx = 1'b1;
      end
   end

   assign init_en = launch && (phase == 2'd1);
   assign ksa_en  = launch && (phase == 2'd2);
   assign prga_en = launch && (phase == 2'd3);
   assign rdy     = (state == IDLE);
   assign err     = err_q;

   // Only the owning engine reaches the port; stray writes from the others are dropped
   always_comb begin
      s_addr   = '0;
      s_wrdata = '0;
      s_wren   = 1'b0;
      case (phase)
         2'd1: begin s_addr = init_addr; s_wrdata = init_wrdata; s_wren = init_wren; end
         2'd2: begin s_addr = ksa_addr;  s_wrdata = ksa_wrdata;  s_wren = ksa_wren;  end
         2'd3: begin s_addr = prga_addr; s_wrdata = prga_wrdata; s_wren = prga_wren; end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_arc4_seq.sv
// Directed bench for arc4_seq: behavioural engines drive the main instance,
// a second instance with a 16-cycle watchdog is driven by a cycle script.
`timescale 1ns/1ps
module tb_arc4_seq;

   logic clk = 1'b0;
   logic rst_n;
   logic en;
   logic rdy, err;
   logic [1:0] phase;
   logic init_en, init_rdy, init_wren, ksa_en, ksa_rdy, ksa_wren, prga_en, prga_rdy, prga_wren;
   logic [7:0] init_addr, init_wrdata, ksa_addr, ksa_wrdata, prga_addr, prga_wrdata;
   logic [7:0] s_addr, s_wrdata;
   logic s_wren;

   logic w_en, w_rdy, w_err;
   logic [1:0] w_phase;
   logic w_init_en, w_init_rdy, w_ksa_en, w_ksa_rdy, w_prga_en, w_prga_rdy;
   logic [7:0] w_s_addr, w_s_wrdata;
   logic w_s_wren;

   int passCnt = 0;
   int totalCnt = 0;

   always #5 clk = ~clk;

   arc4_seq #(.AW(8), .DW(8), .TIMEOUT(0)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .err(err), .phase(phase),
      .init_en(init_en), .init_rdy(init_rdy), .init_addr(init_addr),
      .init_wrdata(init_wrdata), .init_wren(init_wren),
      .ksa_en(ksa_en), .ksa_rdy(ksa_rdy), .ksa_addr(ksa_addr),
      .ksa_wrdata(ksa_wrdata), .ksa_wren(ksa_wren),
      .prga_en(prga_en), .prga_rdy(prga_rdy), .prga_addr(prga_addr),
      .prga_wrdata(prga_wrdata), .prga_wren(prga_wren),
      .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
   );

   arc4_seq #(.AW(8), .DW(8), .TIMEOUT(16)) dutw (
      .clk(clk), .rst_n(rst_n), .en(w_en), .rdy(w_rdy), .err(w_err), .phase(w_phase),
      .init_en(w_init_en), .init_rdy(w_init_rdy), .init_addr(8'h01),
      .init_wrdata(8'h01), .init_wren(1'b0),
      .ksa_en(w_ksa_en), .ksa_rdy(w_ksa_rdy), .ksa_addr(8'h02),
      .ksa_wrdata(8'h02), .ksa_wren(1'b0),
      .prga_en(w_prga_en), .prga_rdy(w_prga_rdy), .prga_addr(8'h03),
      .prga_wrdata(8'h03), .prga_wren(1'b0),
      .s_addr(w_s_addr), .s_wrdata(w_s_wrdata), .s_wren(w_s_wren)
   );

   // Behavioural engines, index 0=init 1=ksa 2=prga: busy for engLen cycles,
   // optionally dropping rdy engLag cycles late
   logic [2:0] engRdyInt, engPend, engForceLow, engForceWr, engEn;
   int engLen [3];
   int engLag [3];
   int engCnt [3];
   int engLagCnt [3];

   assign engEn = {prga_en, ksa_en, init_en};
   assign init_rdy = engRdyInt[0] & ~engForceLow[0];
   assign ksa_rdy  = engRdyInt[1] & ~engForceLow[1];
   assign prga_rdy = engRdyInt[2] & ~engForceLow[2];
   assign init_wren = engForceWr[0] | ~engRdyInt[0];
   assign ksa_wren  = engForceWr[1] | ~engRdyInt[1];
   assign prga_wren = engForceWr[2] | ~engRdyInt[2];
   assign init_addr = engForceWr[0] ? 8'h55 : 8'(engCnt[0]);
   assign ksa_addr  = engForceWr[1] ? 8'h55 : 8'(engCnt[1]);
   assign prga_addr = engForceWr[2] ? 8'h55 : 8'(engCnt[2]);
   assign init_wrdata = engForceWr[0] ? 8'hAA : 8'h11;
   assign ksa_wrdata  = engForceWr[1] ? 8'hAA : 8'h22;
   assign prga_wrdata = engForceWr[2] ? 8'hAA : 8'h33;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         engRdyInt <= 3'b111;
         engPend   <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            engCnt[i]    <= 0;
            engLagCnt[i] <= 0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (engPend[i]) begin
               if (engLagCnt[i] == 0) begin
                  engRdyInt[i] <= 1'b0;
                  engCnt[i]    <= engLen[i];
                  engPend[i]   <= 1'b0;
               end else begin
                  engLagCnt[i] <= engLagCnt[i] - 1;
               end
            end else if (!engRdyInt[i]) begin
               if (engCnt[i] <= 1) engRdyInt[i] <= 1'b1;
               else engCnt[i] <= engCnt[i] - 1;
            end else if (engEn[i] && !engForceLow[i]) begin
               if (engLag[i] == 0) begin
                  engRdyInt[i] <= 1'b0;
                  engCnt[i]    <= engLen[i];
               end else begin
                  engPend[i]   <= 1'b1;
                  engLagCnt[i] <= engLag[i] - 1;
               end
            end
         end
      end
   end

   task automatic setLens(input int a, input int b, input int c);
      engLen[0] = a; engLen[1] = b; engLen[2] = c;
      engLag[0] = 0; engLag[1] = 0; engLag[2] = 0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #3;
      totalCnt++;
      if (rdy !== 1'b1 || err !== 1'b0 || phase !== 2'd0)
         $display("[TB] FAIL reset_status: rdy=%b err=%b phase=%0d, required 1 0 0", rdy, err, phase);
      else passCnt++;
      totalCnt++;
      if ({init_en, ksa_en, prga_en} !== 3'b000)
         $display("[TB] FAIL reset_en: got %b required 000", {init_en, ksa_en, prga_en});
      else passCnt++;
      totalCnt++;
      if (s_wren !== 1'b0 || s_addr !== 8'h00 || s_wrdata !== 8'h00)
         $display("[TB] FAIL reset_port: wren=%b addr=%h data=%h, required 0 00 00", s_wren, s_addr, s_wrdata);
      else passCnt++;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_nominal;
      int initEnCnt = 0, ksaEnCnt = 0, prgaEnCnt = 0;
      int initEnCyc = 0, ksaEnCyc = 0, prgaEnCyc = 0;
      int initRise = 0, ksaRise = 0, prgaRise = 0, doneCyc = 0;
      logic pInit = 1'b1, pKsa = 1'b1, pPrga = 1'b1;
      logic [1:0] ph [7];
      setLens(256, 768, 300);
      en = 1'b1;
      for (int c = 1; c <= 1400; c++) begin
         @(posedge clk); #1;
         en = 1'b0;
         @(negedge clk);
         if (init_en) begin initEnCnt++; initEnCyc = c; end
         if (ksa_en)  begin ksaEnCnt++;  ksaEnCyc = c;  end
         if (prga_en) begin prgaEnCnt++; prgaEnCyc = c; end
         if (init_rdy && !pInit) initRise = c;
         if (ksa_rdy && !pKsa)   ksaRise = c;
         if (prga_rdy && !pPrga) prgaRise = c;
         pInit = init_rdy; pKsa = ksa_rdy; pPrga = prga_rdy;
         if (rdy && doneCyc == 0) doneCyc = c;
         if (c == 1)    ph[0] = phase;
         if (c == 258)  ph[1] = phase;
         if (c == 259)  ph[2] = phase;
         if (c == 1028) ph[3] = phase;
         if (c == 1029) ph[4] = phase;
         if (c == 1330) ph[5] = phase;
         if (c == 1331) ph[6] = phase;
      end
      totalCnt++;
      if (initEnCnt != 1 || initEnCyc != 1)
         $display("[TB] FAIL nom_init_en: count=%0d cycle=%0d, required 1 at 1", initEnCnt, initEnCyc);
      else passCnt++;
      totalCnt++;
      if (ksaEnCnt != 1 || ksaEnCyc != 259 || ksaEnCyc != initRise + 1)
         $display("[TB] FAIL nom_ksa_en: count=%0d cycle=%0d initRise=%0d, required 1 at 259", ksaEnCnt, ksaEnCyc, initRise);
      else passCnt++;
      totalCnt++;
      if (prgaEnCnt != 1 || prgaEnCyc != 1029 || prgaEnCyc != ksaRise + 1)
         $display("[TB] FAIL nom_prga_en: count=%0d cycle=%0d ksaRise=%0d, required 1 at 1029", prgaEnCnt, prgaEnCyc, ksaRise);
      else passCnt++;
      totalCnt++;
      if (doneCyc != 1331 || doneCyc != prgaRise + 1)
         $display("[TB] FAIL nom_done: rdy back at %0d prgaRise=%0d, required 1331", doneCyc, prgaRise);
      else passCnt++;
      totalCnt++;
      if (ph[0] !== 2'd1 || ph[1] !== 2'd1 || ph[2] !== 2'd2 || ph[3] !== 2'd2 ||
          ph[4] !== 2'd3 || ph[5] !== 2'd3 || ph[6] !== 2'd0)
         $display("[TB] FAIL nom_phase: got %0d %0d %0d %0d %0d %0d %0d, required 1 1 2 2 3 3 0",
                  ph[0], ph[1], ph[2], ph[3], ph[4], ph[5], ph[6]);
      else passCnt++;
      totalCnt++;
      if (rdy !== 1'b1 || err !== 1'b0)
         $display("[TB] FAIL nom_end: rdy=%b err=%b, required 1 0", rdy, err);
      else passCnt++;
   endtask

   task automatic test_mux_isolation;
      setLens(4, 4, 4);
      en = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         en = 1'b0;
         if (c == 3)  engForceWr[1] = 1'b1;
         if (c == 4)  engForceWr[1] = 1'b0;
         if (c == 9)  engForceWr[0] = 1'b1;
         if (c == 10) engForceWr[0] = 1'b0;
         if (c == 25) engForceWr = 3'b111;
         if (c == 26) engForceWr = 3'b000;
         @(negedge clk);
         if (c == 3) begin
            totalCnt++;
            if (phase !== 2'd1 || s_wren !== init_wren || s_wren !== 1'b1 ||
                s_addr !== init_addr || s_wrdata !== 8'h11)
               $display("[TB] FAIL mux_phase1: phase=%0d wren=%b addr=%h data=%h, required 1 1 %h 11",
                        phase, s_wren, s_addr, s_wrdata, init_addr);
            else passCnt++;
         end
         if (c == 9) begin
            totalCnt++;
            if (phase !== 2'd2 || s_wren !== 1'b1 || s_addr !== ksa_addr || s_wrdata !== 8'h22)
               $display("[TB] FAIL mux_phase2: phase=%0d wren=%b addr=%h data=%h, required 2 1 %h 22",
                        phase, s_wren, s_addr, s_wrdata, ksa_addr);
            else passCnt++;
         end
         if (c == 25) begin
            totalCnt++;
            if (phase !== 2'd0 || s_wren !== 1'b0 || s_addr !== 8'h00 || s_wrdata !== 8'h00)
               $display("[TB] FAIL mux_idle: phase=%0d wren=%b addr=%h data=%h, required 0 0 00 00",
                        phase, s_wren, s_addr, s_wrdata);
            else passCnt++;
         end
      end
   endtask

   task automatic test_late_engine;
      int ksaEnEarly = 0, holdPh = 0, lagPh = 0;
      logic ksaAt12 = 1'b0, ksaAt13 = 1'b1, prgaAt18 = 1'b0, rdyAt25 = 1'b1, rdyAt26 = 1'b0;
      setLens(4, 4, 4);
      engLag[2] = 2;
      en = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         en = 1'b0;
         if (c == 6)  engForceLow[1] = 1'b1;
         if (c == 12) engForceLow[1] = 1'b0;
         @(negedge clk);
         if (c >= 7 && c <= 11) begin
            if (ksa_en) ksaEnEarly++;
            if (phase == 2'd2) holdPh++;
         end
         if (c == 12) ksaAt12 = ksa_en;
         if (c == 13) ksaAt13 = ksa_en;
         if (c == 18) prgaAt18 = prga_en;
         if ((c == 19 || c == 20) && phase == 2'd3) lagPh++;
         if (c == 25) rdyAt25 = rdy;
         if (c == 26) rdyAt26 = rdy;
      end
      engLag[2] = 0;
      totalCnt++;
      if (ksaEnEarly != 0 || holdPh != 5)
         $display("[TB] FAIL late_hold: ksa_en highs=%0d phase2 cycles=%0d, required 0 5", ksaEnEarly, holdPh);
      else passCnt++;
      totalCnt++;
      if (ksaAt12 !== 1'b1 || ksaAt13 !== 1'b0)
         $display("[TB] FAIL late_pulse: ksa_en c12=%b c13=%b, required 1 0", ksaAt12, ksaAt13);
      else passCnt++;
      totalCnt++;
      if (prgaAt18 !== 1'b1 || lagPh != 2)
         $display("[TB] FAIL late_noadvance: prga_en c18=%b phase3 cycles=%0d, required 1 2", prgaAt18, lagPh);
      else passCnt++;
      totalCnt++;
      if (rdyAt25 !== 1'b0 || rdyAt26 !== 1'b1)
         $display("[TB] FAIL late_done: rdy c25=%b c26=%b, required 0 1", rdyAt25, rdyAt26);
      else passCnt++;
   endtask

   task automatic test_back_to_back;
      int initEnCnt = 0;
      logic rdyAt19 = 1'b0, initAt20 = 1'b0;
      logic [1:0] phAt20 = 2'd0;
      setLens(4, 4, 4);
      en = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (c == 20) en = 1'b0;
         @(negedge clk);
         if (c <= 19 && init_en) initEnCnt++;
         if (c == 19) rdyAt19 = rdy;
         if (c == 20) begin initAt20 = init_en; phAt20 = phase; end
      end
      totalCnt++;
      if (initEnCnt != 1 || rdyAt19 !== 1'b1)
         $display("[TB] FAIL b2b_ignore: init_en count=%0d rdy c19=%b, required 1 1", initEnCnt, rdyAt19);
      else passCnt++;
      totalCnt++;
      if (initAt20 !== 1'b1 || phAt20 !== 2'd1)
         $display("[TB] FAIL b2b_restart: init_en=%b phase=%0d, required 1 1", initAt20, phAt20);
      else passCnt++;
      totalCnt++;
      if (rdy !== 1'b1)
         $display("[TB] FAIL b2b_end: rdy=%b required 1", rdy);
      else passCnt++;
   endtask

   task automatic test_async_reset;
      setLens(4, 4, 4);
      en = 1'b1;
      for (int c = 1; c <= 32; c++) begin
         @(posedge clk); #1;
         en = (c == 10);
         if (c == 9) begin
            totalCnt++;
            if (phase !== 2'd2 || s_wren !== 1'b1)
               $display("[TB] FAIL arst_before: phase=%0d wren=%b, required 2 1", phase, s_wren);
            else passCnt++;
            #2;
            rst_n = 1'b0;
            #0.005;
            totalCnt++;
            if (s_wren !== 1'b0 || phase !== 2'd0 || rdy !== 1'b1)
               $display("[TB] FAIL arst_during: wren=%b phase=%0d rdy=%b, required 0 0 1", s_wren, phase, rdy);
            else passCnt++;
            #0.005;
            rst_n = 1'b1;
         end
         @(negedge clk);
         if (c == 11) begin
            totalCnt++;
            if (init_en !== 1'b1 || phase !== 2'd1)
               $display("[TB] FAIL arst_restart: init_en=%b phase=%0d, required 1 1", init_en, phase);
            else passCnt++;
         end
      end
   endtask

   task automatic test_watchdog;
      for (int c = 0; c <= 32; c++) begin
         @(posedge clk); #1;
         case (c)
            0:  w_en = 1'b1;
            1:  w_en = 1'b0;
            2:  w_init_rdy = 1'b0;
            3:  w_init_rdy = 1'b1;
            5:  w_ksa_rdy = 1'b0;
            6:  w_ksa_rdy = 1'b1;
            8:  w_prga_rdy = 1'b0;
            31: begin w_prga_rdy = 1'b1; w_en = 1'b1; end
            32: w_en = 1'b0;
            default: ;
         endcase
         @(negedge clk);
         if (c == 7) begin
            totalCnt++;
            if (w_prga_en !== 1'b1 || w_phase !== 2'd3)
               $display("[TB] FAIL wd_prga_start: prga_en=%b phase=%0d, required 1 3", w_prga_en, w_phase);
            else passCnt++;
         end
         if (c == 23) begin
            totalCnt++;
            if (w_phase !== 2'd3 || w_err !== 1'b0)
               $display("[TB] FAIL wd_pre: phase=%0d err=%b, required 3 0", w_phase, w_err);
            else passCnt++;
         end
         if (c == 24) begin
            totalCnt++;
            if (w_phase !== 2'd0 || w_rdy !== 1'b1 || w_err !== 1'b1)
               $display("[TB] FAIL wd_abort: phase=%0d rdy=%b err=%b, required 0 1 1", w_phase, w_rdy, w_err);
            else passCnt++;
         end
         if (c == 31) begin
            totalCnt++;
            if (w_err !== 1'b1)
               $display("[TB] FAIL wd_sticky: err=%b required 1", w_err);
            else passCnt++;
         end
         if (c == 32) begin
            totalCnt++;
            if (w_err !== 1'b0 || w_init_en !== 1'b1 || w_phase !== 2'd1)
               $display("[TB] FAIL wd_clear: err=%b init_en=%b phase=%0d, required 0 1 1", w_err, w_init_en, w_phase);
            else passCnt++;
         end
      end
   endtask

   initial begin
      en = 1'b0;
      w_en = 1'b0;
      w_init_rdy = 1'b1;
      w_ksa_rdy = 1'b1;
      w_prga_rdy = 1'b1;
      engForceLow = 3'b000;
      engForceWr = 3'b000;
      setLens(4, 4, 4);
      test_reset();
      test_nominal();
      test_mux_isolation();
      test_late_engine();
      test_back_to_back();
      test_async_reset();
      test_watchdog();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
